fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised multi-lane instruction buffer between icache fetch output and decode.
- Successor to the fixed 2-in/2-out instbuffer. Generalises fetch width, decode width and depth.
- Adds per-lane partial dequeue, an all-or-nothing enqueue handshake, an occupancy output and a separate flush source.
- Each entry carries {pred_taken, pred_addr[31:0], pc[31:0], inst[31:0], is_exception, exception_cause[6:0]}, 105 bits, in that MSB-to-LSB order.

Parameters:
- FETCH_W, 2, lanes written per cycle from icache.
- DEC_W, 2, lanes presented per cycle to decode.
- DEPTH, 16, entries. Must be a power of two and at least 2*max(FETCH_W, DEC_W).
- ENTRY_W, 105, bits per entry.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  synchronous reset, active-high.
- flush_be  in  1  backend flush (redirect/exception).
- flush_bpu  in  1  predictor redirect flush.
- in_valid  in  FETCH_W  per-lane valid. Must be a contiguous prefix from lane 0.
- in_data  in  FETCH_W*ENTRY_W  lane i at bits [i*ENTRY_W +: ENTRY_W].
- in_ready  out  1  free slots >= FETCH_W.
- stall  out  1  equals ~in_ready, drives pc pause.
- out_valid  out  DEC_W  lane i valid iff count > i.
- out_data  out  DEC_W*ENTRY_W  oldest-first entries.
- out_accept  in  DEC_W  consumer take mask. Must be a prefix of out_valid.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular array of DEPTH entries. rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is held separately.
- Enqueue: when in_ready=1, every lane with in_valid set is written at wr_ptr+i. wr_ptr and count advance by popcount(in_valid). When in_ready=0, in_valid is ignored and nothing is written; the source must hold its data.
- in_ready is registered-state combinational: (DEPTH - count) >= FETCH_W. It does not depend on same-cycle dequeue.
- Dequeue: out_data lane i = mem[rd_ptr+i], read asynchronously. rd_ptr advances and count decreases by popcount(out_accept) at the clock edge.
- Lanes with out_valid=0 present 0 on out_data.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq.
- flush = flush_be | flush_bpu. On flush: rd_ptr, wr_ptr and count go to 0 next cycle. Flush overrides any same-cycle enqueue or dequeue; data written in that cycle is discarded.
- Reset: rd_ptr=0, wr_ptr=0, count=0, so out_valid=0, in_ready=1 and stall=0. Memory contents are not reset.
- Reset asserted mid-stream behaves identically to flush. Reset has priority over flush.
- Full (count=DEPTH): out_valid stays all ones where applicable and in_ready=0.
- Empty (count=0): out_valid=0 and out_accept is ignored.
- Illegal input (non-prefix out_accept, or accept beyond out_valid): only the lanes covered by the prefix of out_valid & out_accept are dequeued.
- Wrap-around: lane indices are taken modulo DEPTH on both the read and write side.

Optional Feature:
- Macro: FQ_BYPASS_EN.
- Defined: when count=0 and in_ready=1, in_data lanes are forwarded combinationally onto out_data/out_valid in the same cycle, with out_valid = in_valid truncated to DEC_W. Accepted lanes are not written. Remaining valid lanes are written starting at wr_ptr, and count reflects only those.
- Not defined: minimum enqueue-to-output latency is 1 cycle and out_* depends only on stored state.

Decomposition:
- Package fetch_pkg holds:
  - the ENTRY_W constant;
  - the field offsets (PRED_TAKEN_BIT=104, PRED_ADDR_MSB/LSB=103/72, PC_MSB/LSB=71/40, INST_MSB/LSB=39/8, EXC_BIT=7, CAUSE_MSB/LSB=6/0);
  - a popcount/prefix-count function.
- One sub-module, fq_ptr_ctrl, owns rd_ptr, wr_ptr, count, the flush/reset priority and the in_ready computation. The top holds the memory and the lane muxes.

Test Plan (DEPTH=8, FETCH_W=2, DEC_W=2):
- Reset, then in_valid=2'b11 for 4 cycles with out_accept=0 -> count=8, in_ready=0, stall=1; a 5th-cycle write is dropped and count stays 8.
- Fill with pc 0x1c000000..0x1c00001c, then out_accept=2'b01 -> out_data lane0 becomes 0x1c000004, count=7, in_ready=0; next cycle out_accept=2'b11 -> count=5, in_ready=1.
- Same-cycle enqueue of 2 and accept of 2 at count=3 -> count stays 3 and ordering is preserved; run 20 cycles so pointers wrap at least twice, with no reorder and no loss (scoreboard).
- count=6 with flush_bpu=1 and in_valid=2'b11 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1; a following write with pc 0x1c000100 appears on lane0.
- Entry with is_exception=1 and cause=7'h08 enqueued on lane1 with in_valid=2'b11 -> it emerges on out_data lane1 with bits [7:0]=8'h88 intact.
- FQ_BYPASS_EN build: empty queue, in_valid=2'b01 with pc 0x1c000200 and out_accept=2'b01 in the same cycle -> out_valid=2'b01 that cycle, count remains 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - entry layout constants and lane-count helper for the fetch queue
package fetch_pkg;

  localparam int PRED_TAKEN_BIT = 104;
  localparam int PRED_ADDR_MSB  = 103;
  localparam int PRED_ADDR_LSB  = 72;
  localparam int PC_MSB         = 71;
  localparam int PC_LSB         = 40;
  localparam int INST_MSB       = 39;
  localparam int INST_LSB       = 8;
  localparam int EXC_BIT        = 7;
  localparam int CAUSE_MSB      = 6;
  localparam int CAUSE_LSB      = 0;

  localparam int ENTRY_W        = PRED_TAKEN_BIT + 1;

  // Widest lane mask the helper below accepts.
  localparam int MAX_LANES      = 16;

  // Ranges mirror the absolute bit positions inside a packed entry.
  typedef struct packed {
    logic [PRED_TAKEN_BIT:PRED_TAKEN_BIT] pred_taken;
    logic [PRED_ADDR_MSB:PRED_ADDR_LSB]   pred_addr;
    logic [PC_MSB:PC_LSB]                 pc;
    logic [INST_MSB:INST_LSB]             inst;
    logic [EXC_BIT:EXC_BIT]               is_exception;
    logic [CAUSE_MSB:CAUSE_LSB]           exception_cause;
  } fetch_entry_t;

  // Number of consecutive set bits starting at bit 0.
  function automatic int unsigned prefix_count(input logic [MAX_LANES-1:0] mask);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < MAX_LANES; i++) begin
      run = run & mask[i];
      n   = n + 32'(run);
    end
    return n;
  endfunction

endpackage

// File: rtl/fq_ptr_ctrl.sv
// rtl/fq_ptr_ctrl.sv - read/write pointers, occupancy, flush/reset priority and in_ready
module fq_ptr_ctrl #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [CNT_W-1:0] enq_n,
  input  logic [CNT_W-1:0] deq_n,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             in_ready
);
  import fetch_pkg::*;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Power-of-two depth lets the pointer adds wrap for free.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_n);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_n);
    count_d  = count_q + enq_n - deq_n;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    in_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
    rd_ptr   = rd_ptr_q;
    wr_ptr   = wr_ptr_q;
    count    = count_q;
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - multi-lane icache-to-decode instruction buffer
// FQ_BYPASS_EN: forward incoming lanes straight to decode while the queue is empty.
module fetch_queue #(
  parameter int FETCH_W = 2,
  parameter int DEC_W   = 2,
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = fetch_pkg::ENTRY_W
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       flush_be,
  input  logic                       flush_bpu,
  input  logic [FETCH_W-1:0]         in_valid,
  input  logic [FETCH_W*ENTRY_W-1:0] in_data,
  output logic                       in_ready,
  output logic                       stall,
  output logic [DEC_W-1:0]           out_valid,
  output logic [DEC_W*ENTRY_W-1:0]   out_data,
  input  logic [DEC_W-1:0]           out_accept,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import fetch_pkg::*;

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WIDE_L = (FETCH_W > DEC_W) ? FETCH_W : DEC_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          occ;
  logic                      ready_int;
  logic                      flush;
  logic                      byp_active;
  logic [CNT_W-1:0]          n_in, n_take, enq_n, deq_n, wr_skip;
  logic [DEC_W-1:0]          vis_valid;
  logic [DEC_W*ENTRY_W-1:0]  vis_data;
  logic [WIDE_L-1:0]         in_valid_x;
  logic [WIDE_L*ENTRY_W-1:0] in_data_x;

  always_comb begin
    flush      = flush_be | flush_bpu;
    in_valid_x = WIDE_L'(in_valid);
    in_data_x  = (WIDE_L*ENTRY_W)'(in_data);
    n_in       = CNT_W'(prefix_count(MAX_LANES'(in_valid)));
  end

  // Output lanes: stored entries oldest-first, or the input lanes when bypassing.
  always_comb begin
    vis_valid  = '0;
    vis_data   = '0;
    byp_active = 1'b0;
`ifdef FQ_BYPASS_EN
    byp_active = (occ == '0) && ready_int;
`endif
    for (int i = 0; i < DEC_W; i++) begin
      if (byp_active) begin
        vis_valid[i] = in_valid_x[i];
        if (in_valid_x[i]) begin
          vis_data[i*ENTRY_W +: ENTRY_W] = in_data_x[i*ENTRY_W +: ENTRY_W];
        end
      end else if (occ > CNT_W'(i)) begin
        vis_valid[i] = 1'b1;
        vis_data[i*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    n_take = CNT_W'(prefix_count(MAX_LANES'(vis_valid & out_accept)));
    if (byp_active) begin
      deq_n   = '0;
      wr_skip = n_take;
      enq_n   = n_in - n_take;
    end else begin
      deq_n   = n_take;
      wr_skip = '0;
      enq_n   = ready_int ? n_in : '0;
    end
  end

  // Lanes already consumed through the bypass are skipped; the rest pack from wr_ptr.
  always_comb begin
    mem_d = mem_q;
    if (ready_int && !flush) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if ((CNT_W'(i) >= wr_skip) && (CNT_W'(i) < n_in)) begin
          mem_d[wr_ptr + PTR_W'(i) - PTR_W'(wr_skip)] = in_data[i*ENTRY_W +: ENTRY_W];
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    mem_q <= mem_d;
  end

  fq_ptr_ctrl #(
    .DEPTH   (DEPTH),
    .FETCH_W (FETCH_W),
    .PTR_W   (PTR_W),
    .CNT_W   (CNT_W)
  ) u_ptr_ctrl (
    .clk      (cpu_clk),
    .rst      (cpu_rst),
    .flush    (flush),
    .enq_n    (enq_n),
    .deq_n    (deq_n),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (occ),
    .in_ready (ready_int)
  );

  always_comb begin
    in_ready  = ready_int;
    stall     = ~ready_int;
    out_valid = vis_valid;
    out_data  = vis_data;
    count     = occ;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue (DEPTH=8, 2 in / 2 out)
module tb_fetch_queue;
  localparam int EW = 105;
  localparam int D  = 8;
  localparam int CW = 4;
`ifdef FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          cpu_clk = 1'b0;
  logic          cpu_rst, flush_be, flush_bpu;
  logic [1:0]    in_valid, out_accept;
  logic [2*EW-1:0] in_data;
  logic          in_ready, stall;
  logic [1:0]    out_valid;
  logic [2*EW-1:0] out_data;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] q[$];
  logic [31:0] next_pc = 32'h1c001000;

  fetch_queue #(.FETCH_W(2), .DEC_W(2), .DEPTH(D), .ENTRY_W(EW)) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .flush_be   (flush_be),
    .flush_bpu  (flush_bpu),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_accept (out_accept),
    .count      (count)
  );

  always #5 cpu_clk = ~cpu_clk;

  function automatic logic [EW-1:0] mk(input logic [31:0] pc, input logic exc, input logic [6:0] cause);
    logic [31:0] pa;
    logic [31:0] ins;
    logic        pt;
    pa  = $urandom;
    ins = $urandom;
    pt  = 1'($urandom);
    return {pt, pa, pc, ins, exc, cause};
  endfunction

  function automatic logic [EW-1:0] lane_in(input int i);
    return in_data[i*EW +: EW];
  endfunction

  function automatic logic [EW-1:0] lane_out(input int i);
    return out_data[i*EW +: EW];
  endfunction

  function automatic logic [31:0] pc_of(input logic [EW-1:0] e);
    return e[71:40];
  endfunction

  function automatic int pre(input logic [1:0] m);
    return m[0] ? (m[1] ? 2 : 1) : 0;
  endfunction

  // Reference view of what decode should see this cycle.
  function automatic logic [1:0] m_valid();
    if (BYP && q.size() == 0) return in_valid;
    return {q.size() > 1, q.size() > 0};
  endfunction

  function automatic logic [EW-1:0] m_data(input int i);
    if (BYP && q.size() == 0) return in_valid[i] ? lane_in(i) : '0;
    return (i < q.size()) ? q[i] : '0;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [EW-1:0] l0, input logic [EW-1:0] l1,
                       input logic [1:0] acc, input logic fbe = 1'b0, input logic fbp = 1'b0,
                       input logic rst = 1'b0);
    in_valid   = v;
    in_data    = {l1, l0};
    out_accept = acc;
    flush_be   = fbe;
    flush_bpu  = fbp;
    cpu_rst    = rst;
    #1;
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, 2'b00);
  endtask

  // Advance one clock and update the reference queue from the pre-edge inputs.
  task automatic tick();
    int sz;
    bit rdy;
    int nin;
    int nacc;
    bit byp;
    bit fl;
    logic [EW-1:0] l [2];
    sz   = q.size();
    rdy  = (D - sz) >= 2;
    nin  = pre(in_valid);
    nacc = pre(m_valid() & out_accept);
    byp  = BYP && (sz == 0);
    fl   = cpu_rst | flush_be | flush_bpu;
    l[0] = lane_in(0);
    l[1] = lane_in(1);
    @(posedge cpu_clk);
    #1;
    if (fl) begin
      q.delete();
    end else if (byp) begin
      for (int k = nacc; k < nin; k++) q.push_back(l[k]);
    end else begin
      repeat (nacc) void'(q.pop_front());
      if (rdy) for (int k = 0; k < nin; k++) q.push_back(l[k]);
    end
  endtask

  task automatic test_reset();
    drive(2'b11, mk(32'h1, 0, 0), mk(32'h2, 0, 0), 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    idle();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL reset_out_valid got %b want 00", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, mk(32'h1c000000 + 32'(8*k), 0, 0), mk(32'h1c000004 + 32'(8*k), 0, 0), 2'b00);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got %b want 1", k, in_ready); end
      tick();
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL full_count got %0d want 8", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL full_stall got %b want 1", stall); end
    n_cmp++; if (out_valid !== 2'b11) begin n_bad++; $display("FAIL full_out_valid got %b want 11", out_valid); end
    n_cmp++; if (pc_of(lane_out(0)) !== 32'h1c000000) begin n_bad++; $display("FAIL full_lane0_pc got %h want 1c000000", pc_of(lane_out(0))); end
    drive(2'b11, mk(32'h1c0000f0, 0, 0), mk(32'h1c0000f4, 0, 0), 2'b00);
    tick();
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL drop_count got %0d want 8", count); end
    n_cmp++; if (pc_of(lane_out(1)) !== 32'h1c000004) begin n_bad++; $display("FAIL drop_lane1_pc got %h want 1c000004", pc_of(lane_out(1))); end
    drive(2'b00, '0, '0, 2'b01);
    tick();
    n_cmp++; if (pc_of(lane_out(0)) !== 32'h1c000004) begin n_bad++; $display("FAIL deq1_lane0_pc got %h want 1c000004", pc_of(lane_out(0))); end
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL deq1_count got %0d want 7", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL deq1_in_ready got %b want 0", in_ready); end
    drive(2'b00, '0, '0, 2'b11);
    tick();
    idle();
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL deq2_count got %0d want 5", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL deq2_in_ready got %b want 1", in_ready); end
    n_cmp++; if (pc_of(lane_out(0)) !== 32'h1c00000c) begin n_bad++; $display("FAIL deq2_lane0_pc got %h want 1c00000c", pc_of(lane_out(0))); end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] a, b, c, d, e;
    logic [1:0] v, acc;
    a = mk(32'h1c000400, 0, 0); b = mk(32'h1c000404, 0, 0); c = mk(32'h1c000408, 0, 0);
    d = mk(32'h1c00040c, 0, 0); e = mk(32'h1c000410, 0, 0);
    drive(2'b00, '0, '0, 2'b00, 1'b1);
    tick();
    drive(2'b11, a, b, 2'b00); tick();
    drive(2'b01, c, '0, 2'b00); tick();
    drive(2'b11, d, e, 2'b11);
    n_cmp++; if (lane_out(0) !== a || lane_out(1) !== b) begin n_bad++; $display("FAIL b2b_pre got %h/%h want %h/%h", pc_of(lane_out(0)), pc_of(lane_out(1)), pc_of(a), pc_of(b)); end
    tick();
    n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", count); end
    n_cmp++; if (lane_out(0) !== c || lane_out(1) !== d) begin n_bad++; $display("FAIL b2b_order got %h/%h want %h/%h", pc_of(lane_out(0)), pc_of(lane_out(1)), pc_of(c), pc_of(d)); end
    for (int cyc = 0; cyc < 48; cyc++) begin
      case ($urandom_range(0, 3))
        0: v = 2'b00;
        1: v = 2'b01;
        default: v = 2'b11;
      endcase
      acc = 2'($urandom_range(0, 3));
      drive(v, mk(next_pc, 1'($urandom), 7'($urandom)), mk(next_pc + 4, 0, 0), acc);
      next_pc = next_pc + 8;
      n_cmp++; if (out_valid !== m_valid()) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", cyc, out_valid, m_valid()); end
      n_cmp++; if (lane_out(0) !== m_data(0)) begin n_bad++; $display("FAIL rnd_lane0[%0d] got pc %h want pc %h", cyc, pc_of(lane_out(0)), pc_of(m_data(0))); end
      n_cmp++; if (lane_out(1) !== m_data(1)) begin n_bad++; $display("FAIL rnd_lane1[%0d] got pc %h want pc %h", cyc, pc_of(lane_out(1)), pc_of(m_data(1))); end
      n_cmp++; if (count !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", cyc, count, q.size()); end
      n_cmp++; if (in_ready !== ((D - q.size()) >= 2)) begin n_bad++; $display("FAIL rnd_ready[%0d] got %b want %b", cyc, in_ready, (D - q.size()) >= 2); end
      tick();
    end
    idle();
    n_cmp++; if (count !== CW'(q.size())) begin n_bad++; $display("FAIL rnd_end_count got %0d want %0d", count, q.size()); end
  endtask

  task automatic test_flush();
    drive(2'b00, '0, '0, 2'b00, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, mk(32'h1c000500 + 32'(8*k), 0, 0), mk(32'h1c000504 + 32'(8*k), 0, 0), 2'b00);
      tick();
    end
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL flush_pre_count got %0d want 6", count); end
    drive(2'b11, mk(32'h1c0005f0, 0, 0), mk(32'h1c0005f4, 0, 0), 2'b01, 1'b0, 1'b1);
    tick();
    idle();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 2'b00) begin n_bad++; $display("FAIL flush_out_valid got %b want 00", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    drive(2'b01, mk(32'h1c000100, 0, 0), '0, 2'b00);
    tick();
    idle();
    n_cmp++; if (out_valid !== 2'b01) begin n_bad++; $display("FAIL post_flush_valid got %b want 01", out_valid); end
    n_cmp++; if (pc_of(lane_out(0)) !== 32'h1c000100) begin n_bad++; $display("FAIL post_flush_pc got %h want 1c000100", pc_of(lane_out(0))); end
    drive(2'b11, mk(32'h1c000600, 0, 0), mk(32'h1c000604, 0, 0), 2'b01, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", count); end
  endtask

  task automatic test_exception();
    logic [EW-1:0] l1;
    logic [EW-1:0] o1;
    l1 = mk(32'h1c000304, 1'b1, 7'h08);
    drive(2'b00, '0, '0, 2'b00, 1'b1);
    tick();
    drive(2'b11, mk(32'h1c000300, 1'b0, 7'h00), l1, 2'b00);
    tick();
    idle();
    o1 = lane_out(1);
    n_cmp++; if (o1[7:0] !== 8'h88) begin n_bad++; $display("FAIL exc_bits got %h want 88", o1[7:0]); end
    n_cmp++; if (o1 !== l1) begin n_bad++; $display("FAIL exc_entry got pc %h want pc %h", pc_of(o1), pc_of(l1)); end
    drive(2'b00, '0, '0, 2'b10);
    tick();
    idle();
    n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL illegal_accept_count got %0d want 2", count); end
  endtask

`ifdef FQ_BYPASS_EN
  task automatic test_bypass();
    drive(2'b00, '0, '0, 2'b00, 1'b1);
    tick();
    drive(2'b01, mk(32'h1c000200, 0, 0), '0, 2'b01);
    n_cmp++; if (out_valid !== 2'b01) begin n_bad++; $display("FAIL byp_valid got %b want 01", out_valid); end
    n_cmp++; if (pc_of(lane_out(0)) !== 32'h1c000200) begin n_bad++; $display("FAIL byp_pc got %h want 1c000200", pc_of(lane_out(0))); end
    tick();
    idle();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL byp_count got %0d want 0", count); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_full();
    test_back_to_back();
    test_flush();
    test_exception();
`ifdef FQ_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
